// File: rtl/srt4_quotient_converter.sv
// On-the-fly radix-4 quotient converter for an SRT-4 divider: builds Q/QM from signed digits,
// applies the final remainder correction when SRT4_QCONV_REM_FIX_EN is defined, hands off via valid/ready.
module srt4_quotient_converter #(
    parameter int N      = 8,
    parameter int DIGITS = N / 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         digit_valid,
    input  logic [2:0]   digit,
    input  logic         rem_neg,
    input  logic         q_ready,
    output logic [N-1:0] q_out,
    output logic         q_valid,
    output logic         busy,
    output logic         err
);

    localparam int            CW       = (DIGITS > 1) ? $clog2(DIGITS + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [N-1:0]  q_r;
    logic [N-1:0]  q_nx_s;
    logic [N-1:0]  qm_r;
    logic [N-1:0]  qm_nx_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic          err_r;
    logic          err_nx_s;
    logic [N-1:0]  q_out_r;
    logic [N-1:0]  q_out_nx_s;
    logic          q_valid_r;
    logic          q_valid_nx_s;
    logic          busy_r;
    logic          busy_nx_s;
    logic          digit_ok_s;
    logic [2:0]    digit_eff_s;
    logic          digit_neg_s;
    logic          digit_pos_s;
    logic [1:0]    q_lo_s;
    logic [1:0]    qm_lo_s;

    function automatic logic digit_legal(input logic [2:0] d);
        case (d)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: digit_legal = 1'b1;
            default:                                digit_legal = 1'b0;
        endcase
    endfunction

    // Digit decode: illegal codes collapse to zero, low-order appends for Q and QM.
    always_comb begin
        digit_ok_s  = digit_legal(digit);
        digit_eff_s = 3'b000;
        if (digit_ok_s) begin
            digit_eff_s = digit;
        end else begin
            digit_eff_s = 3'b000;
        end
        digit_neg_s = digit_eff_s[2];
        digit_pos_s = !digit_eff_s[2] && (digit_eff_s != 3'b000);
        // d and 4+d agree mod 4, as do d-1 and 3+d, so one expression serves each register.
        q_lo_s      = digit_eff_s[1:0];
        qm_lo_s     = digit_eff_s[1:0] - 2'd1;
    end

`ifndef SRT4_QCONV_REM_FIX_EN
    logic rem_neg_unused_s;
    assign rem_neg_unused_s = rem_neg;
`endif

    // Next-state and datapath update for the converter FSM.
    always_comb begin
        state_nx_s   = state_r;
        q_nx_s       = q_r;
        qm_nx_s      = qm_r;
        cnt_nx_s     = cnt_r;
        err_nx_s     = err_r;
        q_out_nx_s   = q_out_r;
        q_valid_nx_s = q_valid_r;
        if (start) begin
            state_nx_s   = ST_ACC;
            q_nx_s       = {N{1'b0}};
            qm_nx_s      = {N{1'b1}};
            cnt_nx_s     = {CW{1'b0}};
            err_nx_s     = 1'b0;
            q_valid_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_IDLE;
                end
                ST_ACC: begin
                    if (digit_valid) begin
                        if (digit_neg_s) begin
                            q_nx_s = {qm_r[N-3:0], q_lo_s};
                        end else begin
                            q_nx_s = {q_r[N-3:0], q_lo_s};
                        end
                        if (digit_pos_s) begin
                            qm_nx_s = {q_r[N-3:0], qm_lo_s};
                        end else begin
                            qm_nx_s = {qm_r[N-3:0], qm_lo_s};
                        end
                        if (!digit_ok_s) begin
                            err_nx_s = 1'b1;
                        end else begin
                            err_nx_s = err_r;
                        end
                        cnt_nx_s = cnt_r + CW'(1);
                        if (cnt_r == LAST_CNT) begin
                            state_nx_s = ST_CORR;
                        end else begin
                            state_nx_s = ST_ACC;
                        end
                    end else begin
                        state_nx_s = ST_ACC;
                    end
                end
                ST_CORR: begin
`ifdef SRT4_QCONV_REM_FIX_EN
                    // A negative final remainder means the last digit overshot by one ulp.
                    if (rem_neg) begin
                        q_out_nx_s = qm_r;
                    end else begin
                        q_out_nx_s = q_r;
                    end
`else
                    q_out_nx_s = q_r;
`endif
                    q_valid_nx_s = 1'b1;
                    state_nx_s   = ST_DONE;
                end
                ST_DONE: begin
                    if (q_valid_r && q_ready) begin
                        q_valid_nx_s = 1'b0;
                        state_nx_s   = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
        busy_nx_s = (state_nx_s == ST_ACC) || (state_nx_s == ST_CORR);
    end

    // State, conversion registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            q_r       <= {N{1'b0}};
            qm_r      <= {N{1'b1}};
            cnt_r     <= {CW{1'b0}};
            err_r     <= 1'b0;
            q_out_r   <= {N{1'b0}};
            q_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            q_r       <= q_nx_s;
            qm_r      <= qm_nx_s;
            cnt_r     <= cnt_nx_s;
            err_r     <= err_nx_s;
            q_out_r   <= q_out_nx_s;
            q_valid_r <= q_valid_nx_s;
            busy_r    <= busy_nx_s;
        end
    end

    assign q_out   = q_out_r;
    assign q_valid = q_valid_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule

// File: tb/tb_srt4_quotient_converter.sv
// Self-checking bench for srt4_quotient_converter (N=8): vector table, corner sequences, random divisions.
module tb_srt4_quotient_converter;

`ifdef SRT4_QCONV_REM_FIX_EN
    localparam bit FIX = 1'b1;
`else
    localparam bit FIX = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, digit_valid, rem_neg, q_ready;
    logic [2:0] digit;
    logic [7:0] q_out;
    logic       q_valid, busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    srt4_quotient_converter #(.N(8), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .digit_valid(digit_valid), .digit(digit),
        .rem_neg(rem_neg), .q_ready(q_ready), .q_out(q_out), .q_valid(q_valid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0][2:0] d;       // d[3] is the first (most significant) digit
        logic            rn;
        logic [7:0]      q_fix;
        logic [7:0]      q_nofix;
        logic            e;
        int              rdly;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Quotient as the plain weighted sum of digits, modulo 2^8, minus one ulp when corrected.
    function automatic logic [7:0] ref_q(input logic [3:0][2:0] d, input logic rn, output logic e);
        int acc;
        int v;
        acc = 0;
        e   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            v = $signed(d[i]);
            if (v > 2 || v < -2) begin
                v = 0;
                e = 1'b1;
            end
            acc = acc * 4 + v;
        end
        if (FIX && rn) acc = acc - 1;
        return acc[7:0];
    endfunction

    task automatic run_div(input logic [3:0][2:0] d, input logic rn, input int gap_max,
                           input int rdly, input logic [7:0] exp_q, input logic exp_e,
                           input string tag);
        start       = 1'b1;
        digit_valid = 1'b0;
        rem_neg     = ~rn;
        step();
        start = 1'b0;
        chk({tag, " busy after start"}, busy, 1'b1);
        chk({tag, " err after start"}, err, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                digit_valid = 1'b0;
                digit       = 3'($urandom);
                q_ready     = 1'($urandom);
                step();
            end
            digit_valid = 1'b1;
            digit       = d[i];
            q_ready     = 1'($urandom);
            step();
        end
        // Now in CORR: digit_valid must be ignored, rem_neg is sampled here.
        digit_valid = 1'b1;
        digit       = 3'b011;
        rem_neg     = rn;
        chk({tag, " busy in corr"}, busy, 1'b1);
        chk({tag, " q_valid in corr"}, q_valid, 1'b0);
        step();
        digit_valid = 1'b0;
        q_ready     = 1'b0;
        rem_neg     = 1'($urandom);
        chk({tag, " q_valid"}, q_valid, 1'b1);
        chk({tag, " busy in done"}, busy, 1'b0);
        chk({tag, " q_out"}, q_out, exp_q);
        chk({tag, " err"}, err, exp_e);
        for (int k = 0; k < rdly; k++) begin
            digit_valid = 1'b1;
            digit       = 3'b100;
            step();
            chk({tag, " q_valid held"}, q_valid, 1'b1);
            chk({tag, " q_out held"}, q_out, exp_q);
        end
        digit_valid = 1'b0;
        q_ready     = 1'b1;
        step();
        q_ready = 1'b0;
        chk({tag, " q_valid after ready"}, q_valid, 1'b0);
        chk({tag, " busy after ready"}, busy, 1'b0);
        digit_valid = 1'b1;
        digit       = 3'b101;
        step();
        digit_valid = 1'b0;
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle err"}, err, exp_e);
    endtask

    vec_t vecs[8];

    initial begin
        logic [3:0][2:0] rd;
        logic            re;
        logic [7:0]      rq;
        logic            rn;

        vecs[0] = '{d: {3'd1, 3'd2, 3'b111, 3'd0},    rn: 1'b0, q_fix: 8'h5C, q_nofix: 8'h5C, e: 1'b0, rdly: 0};
        vecs[1] = '{d: {3'd1, 3'd2, 3'b111, 3'd0},    rn: 1'b1, q_fix: 8'h5B, q_nofix: 8'h5C, e: 1'b0, rdly: 1};
        vecs[2] = '{d: {3'd2, 3'b110, 3'd2, 3'b110},  rn: 1'b0, q_fix: 8'h66, q_nofix: 8'h66, e: 1'b0, rdly: 5};
        vecs[3] = '{d: {3'd0, 3'd0, 3'd0, 3'b111},    rn: 1'b0, q_fix: 8'hFF, q_nofix: 8'hFF, e: 1'b0, rdly: 0};
        vecs[4] = '{d: {3'd0, 3'd3, 3'd0, 3'd0},      rn: 1'b0, q_fix: 8'h00, q_nofix: 8'h00, e: 1'b1, rdly: 0};
        vecs[5] = '{d: {3'b110, 3'b110, 3'b110, 3'b110}, rn: 1'b1, q_fix: 8'h55, q_nofix: 8'h56, e: 1'b0, rdly: 2};
        vecs[6] = '{d: {3'd2, 3'd2, 3'd2, 3'd2},      rn: 1'b1, q_fix: 8'hA9, q_nofix: 8'hAA, e: 1'b0, rdly: 0};
        vecs[7] = '{d: {3'b100, 3'd1, 3'b101, 3'd0},  rn: 1'b0, q_fix: 8'h10, q_nofix: 8'h10, e: 1'b1, rdly: 1};

        rst = 1'b1; start = 1'b0; digit_valid = 1'b0; digit = 3'd0; rem_neg = 1'b0; q_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset q_out", q_out, 8'h00);
        chk("reset q_valid", q_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset err", err, 1'b0);
        chk("reset Q", dut.q_r, 8'h00);
        chk("reset QM", dut.qm_r, 8'hFF);

        // Reset in the middle of accumulation, with an illegal digit already seen.
        start = 1'b1; step(); start = 1'b0;
        digit_valid = 1'b1; digit = 3'd1;   step();
        digit = 3'b011; step();
        chk("mid-acc err set", err, 1'b1);
        rst = 1'b1; step(); rst = 1'b0; digit_valid = 1'b0;
        chk("mid-acc rst busy", busy, 1'b0);
        chk("mid-acc rst q_valid", q_valid, 1'b0);
        chk("mid-acc rst err", err, 1'b0);
        chk("mid-acc rst Q", dut.q_r, 8'h00);
        chk("mid-acc rst QM", dut.qm_r, 8'hFF);
        rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
        chk("rst beats start", busy, 1'b0);

        foreach (vecs[i]) begin
            run_div(vecs[i].d, vecs[i].rn, 0, vecs[i].rdly,
                    FIX ? vecs[i].q_fix : vecs[i].q_nofix, vecs[i].e, $sformatf("vec%0d", i));
        end

        // err from the previous division is cleared by the next start.
        run_div({3'd0, 3'd3, 3'd0, 3'd0}, 1'b0, 0, 0, 8'h00, 1'b1, "err div");
        start = 1'b1; step(); start = 1'b0;
        chk("err cleared by start", err, 1'b0);
        chk("busy after restart", busy, 1'b1);

        // Restart after three digits of an abandoned division.
        digit_valid = 1'b1;
        digit = 3'b011; step();
        digit = 3'd2;   step();
        digit = 3'd1;   step();
        digit_valid = 1'b0;
        chk("abandoned err", err, 1'b1);
        run_div({3'd0, 3'd0, 3'd0, 3'd1}, 1'b0, 0, 0, 8'h01, 1'b0, "restart");

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                int r;
                int v;
                r = int'($urandom_range(0, 15));
                if (r < 2) begin
                    rd[i] = 3'($urandom_range(3, 5));
                end else begin
                    v = int'($urandom_range(0, 4)) - 2;
                    rd[i] = v[2:0];
                end
            end
            rn = 1'($urandom);
            rq = ref_q(rd, rn, re);
            run_div(rd, rn, 2, int'($urandom_range(0, 3)), rq, re, $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
